// File: rtl/tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tx_framer
//  Description : Frame-synchronising stage between the bit packer and the
//                UART transmit stream. Every output frame starts with the
//                two-byte sync header (sync0_p, sync1_p), followed by exactly
//                frame_bytes_p payload bytes taken from the packer. The host
//                uses the header to realign after dropped bytes.
//                The output is a single registered entry with ready/valid
//                flow control; input flow control is through ready_o only.
//  Options     : TX_FRAMER_CHECKSUM_EN - when defined, an XOR checksum of the
//                frame's payload bytes is appended after the last payload
//                byte (frame length frame_bytes_p + 3 instead of + 2).
//  Ports       :
//     clk_i         in   1                  clock
//     reset_i       in   1                  synchronous reset, active low
//     ready_o       out  1                  framer accepts a payload byte
//     valid_i       in   1                  packer byte valid
//     data_i        in   width_p            packed payload byte
//     ready_i       in   1                  downstream ready
//     valid_o       out  1                  output byte valid
//     data_o        out  width_p            header, payload or checksum byte
//     frame_done_o  out  1                  pulse after a frame's last byte
//                                           has transferred
//     byte_count_o  out  clog2(fb+1)        payload bytes accepted in frame
//  Revision    : 1.0  initial release
// ============================================================================
module tx_framer #(
   parameter int                 width_p       = 8,
   parameter int                 frame_bytes_p = 3180,
   parameter logic [width_p-1:0] sync0_p       = 8'hA5,
   parameter logic [width_p-1:0] sync1_p       = 8'h5A
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   output logic                                   ready_o,
   input  logic                                   valid_i,
   input  logic [width_p-1:0]                     data_i,
   input  logic                                   ready_i,
   output logic                                   valid_o,
   output logic [width_p-1:0]                     data_o,
   output logic                                   frame_done_o,
   output logic [$clog2(frame_bytes_p+1)-1:0]     byte_count_o
);

   localparam int COUNT_W = $clog2(frame_bytes_p + 1);

   // Count value held just before the final payload handshake of a frame.
   localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(frame_bytes_p - 1);
   localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] HDR1    = 3'd1;
   localparam logic [2:0] PAYLOAD = 3'd2;
   localparam logic [2:0] LAST    = 3'd3;
`ifdef TX_FRAMER_CHECKSUM_EN
   localparam logic [2:0] CSUM    = 3'd4;
`endif

   logic [2:0]          state;
   logic [2:0]          state_nxt;
   logic                can_load;
   logic                out_fire;
   logic                in_fire;
   logic                load_en;
   logic [width_p-1:0]  load_data;
   logic [COUNT_W-1:0]  count_nxt;
   logic                done_nxt;
`ifdef TX_FRAMER_CHECKSUM_EN
   logic [width_p-1:0]  csum;
   logic [width_p-1:0]  csum_nxt;
`endif

   // The output entry can take a new byte when it is empty or is being
   // drained this cycle; draining and loading in the same cycle avoids a
   // bubble.
   assign can_load = !valid_o || ready_i;
   assign out_fire = valid_o && ready_i;

   // Payload is only taken while the frame body is being emitted, so header
   // and checksum slots stall the packer rather than dropping its bytes.
   assign ready_o  = (state == PAYLOAD) && can_load;
   assign in_fire  = valid_i && ready_o;

   // -------------------------------------------------------------------------
   // Next-state and output-entry load selection
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      load_en   = 1'b0;
      load_data = data_o;
      count_nxt = byte_count_o;
      done_nxt  = 1'b0;
`ifdef TX_FRAMER_CHECKSUM_EN
      csum_nxt  = csum;
`endif

      case (state)
         IDLE: begin
            // A pending input byte opens a frame but is not consumed yet.
            if (valid_i && can_load) begin
               load_en   = 1'b1;
               load_data = sync0_p;
               state_nxt = HDR1;
            end
         end

         HDR1: begin
            if (can_load) begin
               load_en   = 1'b1;
               load_data = sync1_p;
               state_nxt = PAYLOAD;
            end
         end

         PAYLOAD: begin
            if (in_fire) begin
               load_en   = 1'b1;
               load_data = data_i;
               count_nxt = byte_count_o + COUNT_ONE;
`ifdef TX_FRAMER_CHECKSUM_EN
               csum_nxt  = csum ^ data_i;
`endif
               if (byte_count_o == COUNT_LAST) begin
`ifdef TX_FRAMER_CHECKSUM_EN
                  state_nxt = CSUM;
`else
                  state_nxt = LAST;
`endif
               end
            end
         end

`ifdef TX_FRAMER_CHECKSUM_EN
         CSUM: begin
            // csum already includes the final payload byte here.
            if (can_load) begin
               load_en   = 1'b1;
               load_data = csum;
               state_nxt = LAST;
            end
         end
`endif

         LAST: begin
            // The entry holds the frame's final byte; close the frame on the
            // edge where it leaves.
            if (out_fire) begin
               done_nxt  = 1'b1;
               count_nxt = '0;
`ifdef TX_FRAMER_CHECKSUM_EN
               csum_nxt  = '0;
`endif
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State, counters and the single-entry output register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state        <= IDLE;
         valid_o      <= 1'b0;
         data_o       <= '0;
         frame_done_o <= 1'b0;
         byte_count_o <= '0;
`ifdef TX_FRAMER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         state        <= state_nxt;
         frame_done_o <= done_nxt;
         byte_count_o <= count_nxt;
`ifdef TX_FRAMER_CHECKSUM_EN
         csum         <= csum_nxt;
`endif
         // Under backpressure (valid_o & !ready_i) can_load is low, so no
         // load happens and the entry holds its byte unchanged.
         if (load_en) begin
            valid_o <= 1'b1;
            data_o  <= load_data;
         end else if (out_fire) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
